// File: rtl/bridge_rx.sv
// Receive-side parser for the ASCII host bridge: turns "Raaaa<EOL>" and
// "Waaaadddd<EOL>" byte streams into single-cycle bus requests.
module bridge_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic [15:0] addr_o,
    output logic [15:0] data_o,
    output logic        rw_o,
    output logic        valid_o
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 32;
    localparam int unsigned CW = 4;

    localparam logic [CW-1:0] READ_NIBS  = CW'(4);
    localparam logic [CW-1:0] WRITE_NIBS = CW'(8);

    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_W  = 8'h57;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [BW-1:0]   nib_buf, nib_buf_n;
    logic [AW-1:0]   addr_n;
    logic [DW-1:0]   data_n;
    logic            rw_n;
    logic            valid_n;

    logic            is_hex_c;
    logic            is_term_c;
    logic [3:0]      nib_c;

    // ASCII hex character classification and decode
    always_comb begin
        is_hex_c = 1'b1;
        nib_c    = 4'h0;
        if (data_i >= 8'h30 && data_i <= 8'h39) begin
            nib_c = 4'(data_i - 8'h30);
        end else if (data_i >= 8'h41 && data_i <= 8'h46) begin
            nib_c = 4'(data_i - 8'h37);
        end else if (data_i >= 8'h61 && data_i <= 8'h66) begin
            nib_c = 4'(data_i - 8'h57);
        end else begin
            is_hex_c = 1'b0;
        end
    end

    assign is_term_c = (data_i == CH_CR) || (data_i == CH_LF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            nib_buf <= '0;
            addr_o  <= '0;
            data_o  <= '0;
            rw_o    <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            nib_buf <= nib_buf_n;
            addr_o  <= addr_n;
            data_o  <= data_n;
            rw_o    <= rw_n;
            valid_o <= valid_n;
        end
    end

    // Next-state and request decode; R/W restart a line from any state
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        nib_buf_n = nib_buf;
        addr_n    = addr_o;
        data_n    = data_o;
        rw_n      = rw_o;
        valid_n   = 1'b0;

        if (valid_i) begin
            if (data_i == CH_R) begin
                state_n   = READ;
                cnt_n     = '0;
                nib_buf_n = '0;
            end else if (data_i == CH_W) begin
                state_n   = WRITE;
                cnt_n     = '0;
                nib_buf_n = '0;
            end else begin
                unique case (state)
                    IDLE: begin
                    end
                    READ: begin
                        if (is_hex_c && cnt < READ_NIBS) begin
                            nib_buf_n = {nib_buf[BW-5:0], nib_c};
                            cnt_n     = cnt + CW'(1);
                        end else if (is_term_c && cnt == READ_NIBS) begin
                            addr_n  = nib_buf[AW-1:0];
                            data_n  = '0;
                            rw_n    = 1'b0;
                            valid_n = 1'b1;
                            state_n = IDLE;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                    WRITE: begin
                        if (is_hex_c && cnt < WRITE_NIBS) begin
                            nib_buf_n = {nib_buf[BW-5:0], nib_c};
                            cnt_n     = cnt + CW'(1);
                        end else if (is_term_c && cnt == WRITE_NIBS) begin
                            addr_n  = nib_buf[BW-1:DW];
                            data_n  = nib_buf[DW-1:0];
                            rw_n    = 1'b1;
                            valid_n = 1'b1;
                            state_n = IDLE;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bridge_rx.sv
// Scoreboard bench for bridge_rx: expected requests are queued as lines are
// driven and matched against every valid_o pulse.
module tb_bridge_rx;

    logic        clk;
    logic        rst;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [15:0] addr_o;
    logic [15:0] data_o;
    logic        rw_o;
    logic        valid_o;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        rw;
    } req_t;

    req_t req_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic prev_valid = 1'b0;

    bridge_rx dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .addr_o  (addr_o),
        .data_o  (data_o),
        .rw_o    (rw_o),
        .valid_o (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every pulse must match the oldest queued request
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            check("pulse_width", 32'(prev_valid), 32'd0);
            if (req_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                req_t r;
                r = req_q.pop_front();
                check("addr", 32'(addr_o), 32'(r.addr));
                check("data", 32'(data_o), 32'(r.data));
                check("rw",   32'(rw_o),   32'(r.rw));
            end
        end
        prev_valid = valid_o;
    end

    task automatic push_req(input logic [15:0] a, input logic [15:0] d, input logic rw);
        req_t r;
        r.addr = a;
        r.data = d;
        r.rw   = rw;
        req_q.push_back(r);
    endtask

    // Called at a negedge; leaves the bench at a negedge after the gap
    task automatic send_byte(input logic [7:0] b, input int gap, input logic exp_pulse);
        data_i  = b;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        data_i  = 8'($urandom_range(0, 255));
        check("latency", 32'(valid_o), 32'(exp_pulse));
        repeat (gap) @(negedge clk);
    endtask

    // pulse_idx: character after which a pulse is due, -1 for none
    task automatic send_str(input string s, input int gap, input int pulse_idx);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(8'(s[i]), gap, (i == pulse_idx));
        end
    endtask

    task automatic check_outs(input string tag, input logic [15:0] a, input logic [15:0] d, input logic rw);
        check({tag, "_addr"}, 32'(addr_o), 32'(a));
        check({tag, "_data"}, 32'(data_o), 32'(d));
        check({tag, "_rw"},   32'(rw_o),   32'(rw));
    endtask

    initial begin
        rst     = 1'b1;
        data_i  = 8'h00;
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check_outs("reset", 16'h0, 16'h0, 1'b0);
        check("reset_valid", 32'(valid_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Read with CR LF: one pulse only
        push_req(16'h1A2F, 16'h0000, 1'b0);
        send_str("R1A2F\r\n", 0, 5);
        repeat (3) @(negedge clk);

        // Write with mixed-case hex, outputs then hold
        push_req(16'h00FF, 16'hBEEF, 1'b1);
        send_str("W00ffBEEF\n", 2, 9);
        repeat (5) @(negedge clk);
        check_outs("hold", 16'h00FF, 16'hBEEF, 1'b1);

        // Malformed lines: no pulse, outputs unchanged
        send_str("R12\r", 0, -1);
        send_str("W1234567\r", 0, -1);
        send_str("R12G4\r", 0, -1);
        send_str("R123456\r", 0, -1);
        send_str("W123456789\r", 0, -1);
        send_str("\r\n", 0, -1);
        repeat (3) @(negedge clk);
        check_outs("malformed", 16'h00FF, 16'hBEEF, 1'b1);

        // Mid-line restart
        push_req(16'h0042, 16'h0000, 1'b0);
        send_str("W12R0042\r", 0, 8);
        repeat (3) @(negedge clk);

        // Back-to-back lines, no gaps then 10-cycle gaps
        push_req(16'h0001, 16'h0000, 1'b0);
        send_str("R0001\r", 0, 5);
        push_req(16'h0002, 16'hABCD, 1'b1);
        send_str("W0002ABCD\r", 0, 9);
        push_req(16'h0001, 16'h0000, 1'b0);
        send_str("R0001\r", 10, 5);
        push_req(16'h0002, 16'hABCD, 1'b1);
        send_str("W0002ABCD\r", 10, 9);
        check_outs("b2b", 16'h0002, 16'hABCD, 1'b1);

        // Async reset mid-line, between clock edges
        send_str("W1234", 0, -1);
        #2 rst = 1'b1;
        #1 check_outs("async_rst", 16'h0, 16'h0, 1'b0);
        check("async_rst_valid", 32'(valid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_str("56\r", 0, -1);
        check_outs("post_rst", 16'h0, 16'h0, 1'b0);
        push_req(16'h0003, 16'h0000, 1'b0);
        send_str("R0003\r", 1, 5);
        repeat (5) @(negedge clk);

        check("missing_pulses", 32'(req_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bridge_rx.md
Name: bridge_rx

Overview:
Receive-side parser for the host-to-FPGA ASCII bridge protocol. Consumes bytes from the UART receiver and decodes read and write request lines into a single-cycle bus request (address, write data, direction, valid). The request feeds the core register/memory chain. Read responses travel back through the transmit bridge as "M" + 4 hex + CR LF.

Parameters:
None. Address and data widths are fixed at 16 bits by the protocol.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
data_i  input  8  received byte from UART receiver
valid_i  input  1  data_i valid; single-cycle strobe, one per byte
addr_o  output  16  decoded request address
data_o  output  16  decoded write data; 0 for reads
rw_o  output  1  request direction: 0 = read, 1 = write
valid_o  output  1  one-cycle pulse marking a complete, well-formed request

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: addr_o=0, data_o=0, rw_o=0, valid_o=0. Internal state=IDLE, nibble count=0, nibble buffer=0.
- Bytes are sampled only on cycles with valid_i=1. Cycles with valid_i=0 never change state.
- Grammar:
  - Read line: 'R' (0x52), then exactly 4 hex chars (address, MS nibble first), then a terminator.
  - Write line: 'W' (0x57), then 4 hex chars (address), then 4 hex chars (data), then a terminator.
  - Terminator: CR (0x0D) or LF (0x0A).
- Hex chars accepted: '0'-'9' (0x30-0x39) = 0-9, 'A'-'F' (0x41-0x46) = 10-15, 'a'-'f' (0x61-0x66) = 10-15. Each accepted nibble shifts into a 32-bit buffer from the LSB end.
- States:
  - IDLE: 'R' -> READ; 'W' -> WRITE; entering either clears the count and buffer. All other bytes, including stray CR/LF, are ignored.
  - READ: hex char with count<4 -> store, count+1. Terminator with count==4 -> emit read. Any other byte -> error handling.
  - WRITE: hex char with count<8 -> store, count+1. Terminator with count==8 -> emit write. Any other byte -> error handling.
- Emit:
  - Outputs are registered. The cycle after the terminator is sampled, valid_o=1 for exactly one cycle. That is a latency of 1 clk from the terminator strobe.
  - Read: addr_o=buffer[15:0], data_o=0, rw_o=0.
  - Write: addr_o=buffer[31:16], data_o=buffer[15:0], rw_o=1.
  - State returns to IDLE.
- addr_o, data_o and rw_o hold their last emitted values until the next emit. They do not change on malformed input.
- Error handling:
  - Non-hex, non-terminator byte, or hex char beyond the required count -> discard the line, return to IDLE, no valid_o.
  - Exception: 'R' or 'W' received mid-line aborts the current line and restarts parsing as a new READ/WRITE line.
  - Terminator arriving early, or after too many nibbles, discards the line silently.
- CR LF pair: the CR emits the request and the LF is then ignored in IDLE. A line therefore produces exactly one request.
- Back-to-back lines: valid_o pulses stay one cycle wide regardless of byte spacing. A new line may begin on the very cycle valid_o is high.
- Reset mid-line: the partial line is discarded, outputs go to reset values immediately, no pulse.
- No backpressure. Downstream must accept a request every time valid_o pulses. UART byte spacing guarantees many idle cycles between pulses.

Test Plan:
- Read: bytes "R1A2F\r\n" -> single valid_o pulse 1 clk after '\r' strobe with addr_o=0x1A2F, rw_o=0, data_o=0. LF produces no second pulse.
- Write: bytes "W00ffBEEF\n" -> single pulse with addr_o=0x00FF, data_o=0xBEEF, rw_o=1. Outputs hold until next request.
- Malformed: "R12\r", "W1234567\r", "R12G4\r", "R123456\r" -> no valid_o pulse. Outputs keep previous values.
- Restart: "W12R0042\r" -> one pulse, read, addr_o=0x0042.
- Back-to-back with gaps: "R0001\rW0002ABCD\r" with 0 and 10 idle cycles between bytes -> two pulses, read 0x0001 then write 0x0002/0xABCD. Each pulse is exactly one cycle wide.
- Async reset: assert rst after "W1234" (asynchronously, between clock edges) -> outputs 0 immediately. Follow-up "56\r" gives no pulse; a fresh "R0003\r" decodes normally.
